alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue/write-back controller that drives `ALUmod` from 16-bit instruction words and retires its results. It accepts one instruction per valid/ready handshake, reads operands from an internal 16×16 register file, and presents registered operand/opcode/opext to the ALU. One cycle later it captures `S` into the destination register and `CLFZN` into a processor status register (PSR). It sits between instruction fetch and `ALUmod` as the producer of ALU inputs and the consumer of ALU outputs.

## Interface
- No parameters. Widths are fixed: 16-bit data, 4-bit register index, 5-bit flags.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `instr` input 16: instruction word. Fields are op=[15:12], rd=[11:8], ext=[7:4], rs=[3:0], imm8=[7:0].
- `instr_valid` input 1: `instr` is valid.
- `instr_ready` output 1: block can accept an instruction.
- `alu_a` output 16: ALU A operand, registered.
- `alu_b` output 16: ALU B operand, registered.
- `alu_opcode` output 4: ALU opcode, registered.
- `alu_opext` output 4: ALU opext, registered.
- `alu_s` input 16: ALU result, combinational from the outputs above.
- `alu_clfzn` input 5: ALU flags.
- `psr` output 5: last captured flags, bit order C,L,F,Z,N.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `dbg_addr` input 4: debug register index.
- `dbg_data` output 16: combinational read of `R[dbg_addr]`.

## Operation
- **States:** IDLE → EXEC → WB → IDLE. There are no other transitions except reset.
- **IDLE:**
  - `instr_ready`=1.
  - On `instr_valid & instr_ready`, latch `instr` and go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC:** load the ALU output registers and go to WB.
  - `alu_opcode`=op and `alu_opext`=ext in all cases; the ALU ignores ext for immediate forms.
  - **Register form** (op ∈ {0000, 1010}):
    - `alu_a`=R[rd] and `alu_b`=R[rs].
    - Exception MOV (0000_1101): `alu_a`=R[rs].
  - **Immediate form** (all other op):
    - `alu_b`=sign-extended imm8.
    - Exception ADDUI (0110): `alu_b`=zero-extended imm8.
    - `alu_a`=R[rd].
    - Exception MOVI (1101): `alu_a`=zero-extended imm8.
- **WB:** sample `alu_s` and `alu_clfzn`, pulse `retire`=1, go to IDLE.
  - **Write-back:** R[rd] ← `alu_s` unless the instruction is NOP (0000_0000), CMP (0000_1011), CMPI (1011_xxxx) or CMPU/I (1010_0010).
  - **PSR:** PSR ← `alu_clfzn` for every instruction except NOP.
  - Unrecognised encodings: the ALU returns S=0 and flags=0. They are written back like any other non-compare instruction; the block does not trap them.
- **Register file:**
  - 16 entries, all writable (R0 is not hardwired).
  - Exactly one write port, used only in WB.
  - `dbg_data` reflects a WB write from the cycle after the write edge.
- **Reset:**
  - State=IDLE.
  - R0–R15=0, PSR=0, `alu_a`/`alu_b`/`alu_opcode`/`alu_opext`=0.
  - `retire`=0, `instr_ready`=0 while `reset`=1.
- **Reset mid-instruction** (EXEC or WB): the instruction is abandoned. No register or PSR write, no `retire` pulse.

## Timing
- **Handshake:**
  - `instr_ready`=(state==IDLE)&~reset, decoded from the state register.
  - `instr_valid` may stay high continuously; the next word is taken on the next IDLE cycle.
  - `instr` is only sampled on the handshake edge.
- **Latency, handshake at edge t:**
  - ALU inputs are valid after edge t+1 (EXEC).
  - R[rd], PSR and `retire` update at edge t+2 (WB).
  - `instr_ready` is high again after edge t+2.
- **Throughput:** one instruction per 3 cycles.
- **Back-to-back dependency:** the next instruction reads R[rd] in EXEC at t+4, after the write at t+2. No forwarding is needed.
- **Combinational path:** the ALU sits between the output registers and the WB capture. The full `ALUmod` delay is budgeted in one cycle.
- `retire` is high for exactly one cycle per completed instruction and is never high in consecutive cycles.

## Test plan
- **Reset, then MOVI:**
  - Stimulus: `reset` 2 cycles, then MOVI R3,#0x7F (0xD37F).
  - Response: `instr_ready`=0 during reset. R3=0x007F at the 3rd cycle after the handshake, `retire` 1 cycle, PSR=00000.
- **ADDI sign-extension and overflow:**
  - Stimulus: MOVI R1,#0x7F; ADDI R1,#0xFF (0x51FF).
  - Response: `alu_b`=0xFFFF in EXEC, R1=0x007E, PSR.C=1.
- **ADDUI zero-extension:**
  - Stimulus: R2=0x0001; ADDUI R2,#0xFF (0x62FF).
  - Response: `alu_b`=0x00FF, R2=0x0100, PSR.C=0.
- **CMP suppresses write-back:**
  - Stimulus: R4=5, R5=5; CMP R4,R5 (0x04B5).
  - Response: R4 stays 5, PSR.Z=1, `retire` pulses once.
- **Back-to-back with stalled valid:**
  - Stimulus: `instr_valid` held high with 3 queued SUB words (R6=10, SUB R6,R7 with R7=3, repeated).
  - Response: handshakes exactly 3 cycles apart, R6=10→7→4→1, no gap errors.
- **Reset mid-operation:**
  - Stimulus: `reset` asserted during WB of MOVI R8,#0x55.
  - Response: R8=0, PSR=0, no `retire` pulse, state IDLE after reset deasserts.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for ALUmod: decodes a 16-bit instruction word,
// registers the ALU operands, then retires S/CLFZN into the register file and PSR.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_opext,
  input  logic [15:0] alu_s,
  input  logic [4:0]  alu_clfzn,
  output logic [4:0]  psr,
  output logic        retire,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_hs;
  logic        w_load_alu;
  logic        w_wb;

  logic [15:0] r_instr;
  logic [15:0] r_rf [0:15];
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [3:0]  r_alu_opcode;
  logic [3:0]  r_alu_opext;
  logic [4:0]  r_psr;
  logic        r_retire;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_ext;
  logic [3:0]  w_rs;
  logic [7:0]  w_imm;
  logic        w_reg_form;
  logic        w_is_mov;
  logic        w_is_nop;
  logic        w_is_cmp;
  logic        w_rf_we;
  logic        w_psr_we;
  logic [15:0] w_a;
  logic [15:0] w_b;

  assign w_op  = r_instr[15:12];
  assign w_rd  = r_instr[11:8];
  assign w_ext = r_instr[7:4];
  assign w_rs  = r_instr[3:0];
  assign w_imm = r_instr[7:0];

  // Ready is decoded from the state register and forced low while reset is held.
  assign instr_ready = (r_state == S_IDLE) & ~reset;
  assign w_hs        = instr_valid & instr_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and phase strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_alu  = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_load_alu  = 1'b1;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand selection for register and immediate forms.
  always_comb begin
    w_reg_form = (w_op == 4'b0000) | (w_op == 4'b1010);
    w_is_mov   = (w_op == 4'b0000) & (w_ext == 4'b1101);
    w_a        = r_rf[w_rd];
    w_b        = r_rf[w_rs];
    if (w_reg_form) begin
      if (w_is_mov) begin
        w_a = r_rf[w_rs];
      end else begin
        w_a = r_rf[w_rd];
      end
      w_b = r_rf[w_rs];
    end else begin
      if (w_op == 4'b0110) begin
        w_b = {8'h00, w_imm};
      end else begin
        w_b = {{8{w_imm[7]}}, w_imm};
      end
      if (w_op == 4'b1101) begin
        w_a = {8'h00, w_imm};
      end else begin
        w_a = r_rf[w_rd];
      end
    end
  end

  // Compares only update flags; NOP touches nothing.
  assign w_is_nop = (w_op == 4'b0000) & (w_ext == 4'b0000);
  assign w_is_cmp = ((w_op == 4'b0000) & (w_ext == 4'b1011)) |
                    (w_op == 4'b1011) |
                    ((w_op == 4'b1010) & (w_ext == 4'b0010));
  assign w_rf_we  = w_wb & ~w_is_nop & ~w_is_cmp;
  assign w_psr_we = w_wb & ~w_is_nop;

  // Instruction latch, loaded on the handshake edge only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= 16'h0000;
    end else if (w_hs) begin
      r_instr <= instr;
    end else begin
      r_instr <= r_instr;
    end
  end

  // ALU input registers, loaded in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a      <= 16'h0000;
      r_alu_b      <= 16'h0000;
      r_alu_opcode <= 4'h0;
      r_alu_opext  <= 4'h0;
    end else if (w_load_alu) begin
      r_alu_a      <= w_a;
      r_alu_b      <= w_b;
      r_alu_opcode <= w_op;
      r_alu_opext  <= w_ext;
    end else begin
      r_alu_a      <= r_alu_a;
      r_alu_b      <= r_alu_b;
      r_alu_opcode <= r_alu_opcode;
      r_alu_opext  <= r_alu_opext;
    end
  end

  // Register file with its single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= 16'h0000;
      end
    end else if (w_rf_we) begin
      r_rf[w_rd] <= alu_s;
    end else begin
      r_rf[w_rd] <= r_rf[w_rd];
    end
  end

  // PSR capture and retire pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psr    <= 5'b00000;
      r_retire <= 1'b0;
    end else begin
      r_retire <= w_wb;
      if (w_psr_we) begin
        r_psr <= alu_clfzn;
      end else begin
        r_psr <= r_psr;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign alu_opext  = r_alu_opext;
  assign psr        = r_psr;
  assign retire     = r_retire;
  assign dbg_data   = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: an ALU stub closes the loop, and an
// instruction-level model predicts every output each cycle.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_opcode, alu_opext;
  logic [4:0]  alu_clfzn, psr;
  logic        retire;
  logic [3:0]  dbg_addr = 4'h0;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_opext(alu_opext), .alu_s(alu_s),
    .alu_clfzn(alu_clfzn), .psr(psr), .retire(retire),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Small ALU stand-in: returns {C,L,F,Z,N, S}; unknown encodings give zeros.
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [3:0] ext,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] s;
    logic [4:0]  f;
    logic        add, sub, mov;
    s = 16'h0000; f = 5'b00000; add = 1'b0; sub = 1'b0; mov = 1'b0;
    case (op)
      4'h0: begin
        case (ext)
          4'h5:       add = 1'b1;
          4'h9, 4'hB: sub = 1'b1;
          4'hD:       mov = 1'b1;
          default:    ;
        endcase
      end
      4'h5, 4'h6: add = 1'b1;
      4'h9, 4'hB: sub = 1'b1;
      4'hA:       sub = (ext == 4'h2);
      4'hD:       mov = 1'b1;
      default:    ;
    endcase
    if (add) begin
      t = {1'b0, a} + {1'b0, b};
      s = t[15:0];
      f[4] = t[16];
      f[2] = (a[15] == b[15]) && (s[15] != a[15]);
      f[1] = (s == 16'h0000);
      f[0] = s[15];
    end else if (sub) begin
      s = a - b;
      f[4] = (a < b);
      f[3] = (a < b);
      f[2] = (a[15] != b[15]) && (s[15] != a[15]);
      f[1] = (s == 16'h0000);
      f[0] = s[15];
    end else if (mov) begin
      s = a;
    end
    return {f, s};
  endfunction

  assign {alu_clfzn, alu_s} = alu_fn(alu_opcode, alu_opext, alu_a, alu_b);

  // ---------------- instruction-level model ----------------
  logic [15:0] m_rf [16];
  logic [4:0]  m_psr;
  logic [15:0] m_instr, e_a, e_b;
  logic [3:0]  e_op, e_ext;
  logic        e_retire;
  int          edge_n  = 0;
  int          hs_edge = -100;

  task automatic model_step();
    logic [20:0] r;
    logic [3:0]  op, ext, rd, rs;
    logic [7:0]  imm;
    logic        nop, cmp;
    edge_n++;
    op = m_instr[15:12]; rd = m_instr[11:8]; ext = m_instr[7:4]; rs = m_instr[3:0];
    imm = m_instr[7:0];
    if (reset) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
      m_psr = 5'b00000; e_a = 16'h0000; e_b = 16'h0000; e_op = 4'h0; e_ext = 4'h0;
      e_retire = 1'b0; hs_edge = -100; m_instr = 16'h0000;
    end else begin
      e_retire = 1'b0;
      if (edge_n == hs_edge + 1) begin
        e_op = op; e_ext = ext;
        if (op == 4'h0 || op == 4'hA) begin
          e_a = (op == 4'h0 && ext == 4'hD) ? m_rf[rs] : m_rf[rd];
          e_b = m_rf[rs];
        end else begin
          e_b = (op == 4'h6) ? {8'h00, imm} : {{8{imm[7]}}, imm};
          e_a = (op == 4'hD) ? {8'h00, imm} : m_rf[rd];
        end
      end
      if (edge_n == hs_edge + 2) begin
        r   = alu_fn(e_op, e_ext, e_a, e_b);
        nop = (op == 4'h0) && (ext == 4'h0);
        cmp = (op == 4'h0 && ext == 4'hB) || (op == 4'hB) || (op == 4'hA && ext == 4'h2);
        if (!nop) m_psr = r[20:16];
        if (!nop && !cmp) m_rf[rd] = r[15:0];
        e_retire = 1'b1;
      end
      if (edge_n >= hs_edge + 3 && instr_valid) begin
        hs_edge = edge_n;
        m_instr = instr;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    @(posedge clk);
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      check("instr_ready", {31'd0, instr_ready}, {31'd0, (!reset && edge_n >= hs_edge + 2)});
      check("retire", {31'd0, retire}, {31'd0, e_retire});
      check("psr", {27'd0, psr}, {27'd0, m_psr});
      check("alu_a", {16'd0, alu_a}, {16'd0, e_a});
      check("alu_b", {16'd0, alu_b}, {16'd0, e_b});
      check("alu_opcode", {28'd0, alu_opcode}, {28'd0, e_op});
      check("alu_opext", {28'd0, alu_opext}, {28'd0, e_ext});
      check("dbg_data", {16'd0, dbg_data}, {16'd0, m_rf[dbg_addr]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [15:0] w);
    bit got;
    got = 1'b0;
    instr = w;
    instr_valid = 1'b1;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (hs_edge == edge_n) got = 1'b1;
    end
    instr_valid = 1'b0;
    if (!got) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic exec_one(input logic [15:0] w, output logic [15:0] b_seen,
                          output logic rt_seen, output logic [4:0] psr_seen);
    issue(w);
    @(negedge clk); #1 b_seen = alu_b;
    @(negedge clk); #1;
    rt_seen  = retire;
    psr_seen = psr;
  endtask

  task automatic peek(input logic [3:0] a, output logic [15:0] d);
    dbg_addr = a;
    #1 d = dbg_data;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [31:0] r;
    logic [3:0]  rd, rs;
    logic [7:0]  imm;
    r = $urandom; rd = r[3:0]; rs = r[7:4]; imm = r[15:8];
    case ($urandom_range(0, 11))
      0:       return {4'h0, rd, 4'h5, rs};
      1:       return {4'h0, rd, 4'h9, rs};
      2:       return {4'h0, rd, 4'hD, rs};
      3:       return {4'h0, rd, 4'hB, rs};
      4:       return {4'h0, rd, 4'h0, rs};
      5:       return {4'h5, rd, imm};
      6:       return {4'h6, rd, imm};
      7:       return {4'hB, rd, imm};
      8, 9:    return {4'hD, rd, imm};
      10:      return {4'hA, rd, 4'h2, rs};
      default: return r[31:16];
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] b, d;
    logic        rt;
    logic [4:0]  ps;
    int          hs_t[$];
    logic [15:0] vals[$];

    @(negedge clk);
    check("ready_in_reset", {31'd0, instr_ready}, 32'd0);
    check("retire_in_reset", {31'd0, retire}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // MOVI R3,#0x7F
    exec_one(16'hD37F, b, rt, ps);
    check("movi_retire", {31'd0, rt}, 32'd1);
    check("movi_psr", {27'd0, ps}, 32'd0);
    peek(4'd3, d);
    check("movi_r3", {16'd0, d}, 32'h007F);
    check("model_r3", {16'd0, m_rf[3]}, 32'h007F);
    @(negedge clk); #1;
    check("movi_retire_drop", {31'd0, retire}, 32'd0);

    // ADDI sign extension with carry out
    exec_one(16'hD17F, b, rt, ps);
    exec_one(16'h51FF, b, rt, ps);
    check("addi_b", {16'd0, b}, 32'h0000FFFF);
    peek(4'd1, d);
    check("addi_r1", {16'd0, d}, 32'h007E);
    check("addi_psr", {27'd0, ps}, 32'h10);
    check("model_r1", {16'd0, m_rf[1]}, 32'h007E);

    // ADDUI zero extension
    exec_one(16'hD201, b, rt, ps);
    exec_one(16'h62FF, b, rt, ps);
    check("addui_b", {16'd0, b}, 32'h00FF);
    peek(4'd2, d);
    check("addui_r2", {16'd0, d}, 32'h0100);
    check("addui_c", {31'd0, ps[4]}, 32'd0);

    // CMP does not write back
    exec_one(16'hD405, b, rt, ps);
    exec_one(16'hD505, b, rt, ps);
    exec_one(16'h04B5, b, rt, ps);
    check("cmp_retire", {31'd0, rt}, 32'd1);
    peek(4'd4, d);
    check("cmp_r4", {16'd0, d}, 32'h0005);
    check("cmp_psr", {27'd0, ps}, 32'h02);
    @(negedge clk); #1;
    check("cmp_retire_once", {31'd0, retire}, 32'd0);

    // Back-to-back SUB R6,R7 with valid held high
    exec_one(16'hD60A, b, rt, ps);
    exec_one(16'hD703, b, rt, ps);
    dbg_addr = 4'd6;
    instr = 16'h0697;
    instr_valid = 1'b1;
    for (int c = 0; c < 20 && vals.size() < 3; c++) begin
      @(negedge clk); #1;
      if (hs_t.size() == 3) instr_valid = 1'b0;
      if (retire) vals.push_back(dbg_data);
      if (instr_ready && instr_valid) hs_t.push_back(edge_n + 1);
    end
    instr_valid = 1'b0;
    check("b2b_hs_count", hs_t.size(), 32'd3);
    check("b2b_retire_count", vals.size(), 32'd3);
    if (hs_t.size() == 3) begin
      check("b2b_gap1", hs_t[1] - hs_t[0], 32'd3);
      check("b2b_gap2", hs_t[2] - hs_t[1], 32'd3);
    end
    if (vals.size() == 3) begin
      check("b2b_r6_a", {16'd0, vals[0]}, 32'h0007);
      check("b2b_r6_b", {16'd0, vals[1]}, 32'h0004);
      check("b2b_r6_c", {16'd0, vals[2]}, 32'h0001);
    end

    // Reset during WB of MOVI R8,#0x55
    exec_one(16'hD9AA, b, rt, ps);
    issue(16'hD855);
    @(negedge clk);
    reset = 1'b1;
    #1 check("mid_ready_in_reset", {31'd0, instr_ready}, 32'd0);
    @(negedge clk); #1;
    check("mid_no_retire", {31'd0, retire}, 32'd0);
    check("mid_psr", {27'd0, psr}, 32'd0);
    peek(4'd8, d);
    check("mid_r8", {16'd0, d}, 32'd0);
    reset = 1'b0;
    #1 check("mid_idle_after", {31'd0, instr_ready}, 32'd1);
    @(negedge clk); #1;
    check("mid_no_late_retire", {31'd0, retire}, 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      instr_valid = ($urandom_range(0, 3) != 0);
      instr       = rand_instr();
      dbg_addr    = 4'($urandom_range(0, 15));
      reset       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
